bullet_ctrl: RTL and testbench

BULLET_CTRL -- requirements
Module: bullet_ctrl

---
 rtl/bullet_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// Bullet slot manager: per-frame sequential update of NSLOT bullets with wall bounce,
// lifetime expiry, and cooldown-gated spawning from the tank position and heading.
module bullet_ctrl #(
  parameter int unsigned NSLOT    = 4,
  parameter int unsigned LIFETIME = 300,
  parameter int unsigned COOLDOWN = 8,
  parameter int unsigned SPEED    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_vs,
  input  logic                   fire,
  input  logic [9:0]             TankX,
  input  logic [9:0]             TankY,
  input  logic signed [7:0]      Sin,
  input  logic signed [7:0]      Cos,
  output logic [NSLOT*10-1:0]    BulletX,
  output logic [NSLOT*10-1:0]    BulletY,
  output logic [NSLOT-1:0]       BulletActive,
  output logic                   busy
);

  localparam int unsigned PW = 10;
  localparam int unsigned XW = 16;
  localparam int unsigned VW = 12;
  localparam int unsigned LW = 10;
  localparam int unsigned SW = 18;
  localparam int unsigned MW = 20;
  localparam int unsigned CW = $clog2(COOLDOWN + 1);
  localparam int unsigned IW = $clog2(NSLOT);

  localparam logic signed [SW-1:0] X_OVER = SW'(640 * 64);
  localparam logic signed [SW-1:0] Y_OVER = SW'(480 * 64);
  localparam logic [XW-1:0]        X_MAX  = XW'(639 * 64);
  localparam logic [XW-1:0]        Y_MAX  = XW'(479 * 64);
  localparam logic signed [MW-1:0] SPD    = MW'(SPEED);
  localparam logic signed [MW-1:0] V_HI   = MW'(2047);
  localparam logic signed [MW-1:0] V_LO   = MW'(-2048);

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              vs_q, fire_q, tick_q, pending, busy_nxt;
  logic [CW-1:0]     cooldown;
  logic              tick_d, fire_edge, tick_ok, upd_en, spawn_en;
  logic              free_found;
  logic [IW-1:0]     free_idx;

  logic [XW-1:0]     x [NSLOT];
  logic [XW-1:0]     y [NSLOT];
  logic [VW-1:0]     vx [NSLOT];
  logic [VW-1:0]     vy [NSLOT];
  logic [LW-1:0]     life [NSLOT];
  logic [NSLOT-1:0]  active;

  logic signed [SW-1:0] sum_x, sum_y;
  logic [XW-1:0]        nx, ny;
  logic [VW-1:0]        nvx, nvy, spawn_vx, spawn_vy;

  // Velocity negation that cannot overflow the most negative value.
  function automatic logic [VW-1:0] neg_v(input logic [VW-1:0] v);
    if (v == {1'b1, {(VW-1){1'b0}}}) return {1'b0, {(VW-1){1'b1}}};
    return VW'(~v + VW'(1));
  endfunction

  function automatic logic [VW-1:0] sat_v(input logic signed [MW-1:0] p);
    if (p > V_HI) return {1'b0, {(VW-1){1'b1}}};
    if (p < V_LO) return {1'b1, {(VW-1){1'b0}}};
    return VW'(p);
  endfunction

  assign tick_d    = frame_vs & ~vs_q;
  assign fire_edge = fire & ~fire_q;
  assign tick_ok   = (state == IDLE) && tick_q;

  // Sequencer: one slot per UPDATE cycle, then a single SPAWN cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    upd_en    = 1'b0;
    spawn_en  = 1'b0;
    case (state)
      IDLE: begin
        if (tick_q) begin
          state_nxt = UPDATE;
          idx_nxt   = '0;
        end
      end
      UPDATE: begin
        upd_en = active[idx];
        if (idx == IW'(NSLOT - 1)) state_nxt = SPAWN;
        else                       idx_nxt   = idx + IW'(1);
      end
      SPAWN: begin
        spawn_en  = pending && (cooldown == '0) && free_found;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // busy also covers the cycle in which the registered tick is seen.
    busy_nxt = (state_nxt != IDLE) || tick_d;
  end

  // Lowest-index free slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Motion step with wall bounce for the slot under update.
  always_comb begin
    sum_x = $signed({2'b00, x[idx]}) + $signed({{(SW-VW){vx[idx][VW-1]}}, vx[idx]});
    sum_y = $signed({2'b00, y[idx]}) + $signed({{(SW-VW){vy[idx][VW-1]}}, vy[idx]});
    nx  = sum_x[XW-1:0];
    nvx = vx[idx];
    ny  = sum_y[XW-1:0];
    nvy = vy[idx];
    if (sum_x[SW-1]) begin
      nx  = '0;
      nvx = neg_v(vx[idx]);
    end else if (sum_x >= X_OVER) begin
      nx  = X_MAX;
      nvx = neg_v(vx[idx]);
    end
    if (sum_y[SW-1]) begin
      ny  = '0;
      nvy = neg_v(vy[idx]);
    end else if (sum_y >= Y_OVER) begin
      ny  = Y_MAX;
      nvy = neg_v(vy[idx]);
    end
    spawn_vx = sat_v($signed(MW'(Cos)) * SPD);
    spawn_vy = sat_v(-($signed(MW'(Sin)) * SPD));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      vs_q     <= 1'b0;
      fire_q   <= 1'b0;
      tick_q   <= 1'b0;
      pending  <= 1'b0;
      cooldown <= '0;
      busy     <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      vs_q   <= frame_vs;
      fire_q <= fire;
      tick_q <= tick_d;
      busy   <= busy_nxt;
      // In SPAWN the old request is consumed; an edge in that same cycle carries over.
      if (state == SPAWN) pending <= fire_edge;
      else if (fire_edge) pending <= 1'b1;
      if (spawn_en)                          cooldown <= CW'(COOLDOWN);
      else if (tick_ok && cooldown != '0)    cooldown <= cooldown - CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        x[i]    <= '0;
        y[i]    <= '0;
        vx[i]   <= '0;
        vy[i]   <= '0;
        life[i] <= '0;
      end
    end else begin
      if (upd_en) begin
        x[idx]    <= nx;
        y[idx]    <= ny;
        vx[idx]   <= nvx;
        vy[idx]   <= nvy;
        life[idx] <= life[idx] - LW'(1);
        if (life[idx] == LW'(1)) active[idx] <= 1'b0;
      end
      if (spawn_en) begin
        x[free_idx]      <= {TankX, 6'b000000};
        y[free_idx]      <= {TankY, 6'b000000};
        vx[free_idx]     <= spawn_vx;
        vy[free_idx]     <= spawn_vy;
        life[free_idx]   <= LW'(LIFETIME);
        active[free_idx] <= 1'b1;
      end
    end
  end

  // Registered pixel positions and active flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BulletX      <= '0;
      BulletY      <= '0;
      BulletActive <= '0;
    end else begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        BulletX[i*PW +: PW] <= x[i][XW-1:6];
        BulletY[i*PW +: PW] <= y[i][XW-1:6];
      end
      BulletActive <= active;
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: spawn, motion, bounce, cooldown, slot exhaustion,
// lifetime expiry and mid-sequence reset.
module tb_bullet_ctrl;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_vs;
  logic              fire;
  logic [9:0]        TankX;
  logic [9:0]        TankY;
  logic signed [7:0] Sin;
  logic signed [7:0] Cos;
  logic [39:0]       BulletX;
  logic [39:0]       BulletY;
  logic [3:0]        BulletActive;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int bc;

  bullet_ctrl #(.NSLOT(4), .LIFETIME(300), .COOLDOWN(8), .SPEED(2)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_vs     (frame_vs),
    .fire         (fire),
    .TankX        (TankX),
    .TankY        (TankY),
    .Sin          (Sin),
    .Cos          (Cos),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .BulletActive (BulletActive),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic shoot();
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk) fire = 1'b0;
  endtask

  // One frame tick; optional second tick while busy and optional fire edge during UPDATE.
  task automatic frame(input bit dbl, input bit upd_fire, output int cnt);
    cnt = 0;
    @(negedge Clk) frame_vs = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (busy) cnt++;
      frame_vs = dbl && (c == 2);
      fire     = upd_fire && (c == 1);
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    frame_vs = 1'b0;
    fire     = 1'b0;
    TankX    = 10'd320;
    TankY    = 10'd240;
    Cos      = 8'sd64;
    Sin      = 8'sd0;
    #12;
    chk("rst_x", BulletX, 40'd0);
    chk("rst_y", BulletY, 40'd0);
    chk("rst_active", 40'(BulletActive), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // F1: first shot from screen centre heading +X
    shoot();
    frame(1'b0, 1'b0, bc);
    chk("f1_busy_cycles", 40'(bc), 40'd6);
    chk("f1_active", 40'(BulletActive), 40'b0001);
    chk("f1_x0", 40'(BulletX[9:0]), 40'd320);
    chk("f1_y0", 40'(BulletY[9:0]), 40'd240);
    frame(1'b0, 1'b0, bc);
    chk("f2_x0", 40'(BulletX[9:0]), 40'd322);
    // F3: extra tick while busy is ignored
    frame(1'b1, 1'b0, bc);
    chk("f3_busy_cycles", 40'(bc), 40'd6);
    chk("f3_x0", 40'(BulletX[9:0]), 40'd324);
    // F4: shot inside cooldown is dropped
    shoot();
    frame(1'b0, 1'b0, bc);
    chk("f4_active", 40'(BulletActive), 40'b0001);
    chk("f4_x0", 40'(BulletX[9:0]), 40'd326);
    repeat (5) frame(1'b0, 1'b0, bc);

    // F10: second shot near right wall
    TankX = 10'd638;
    TankY = 10'd100;
    shoot();
    frame(1'b0, 1'b0, bc);
    chk("f10_active", 40'(BulletActive), 40'b0011);
    chk("f10_x1", 40'(BulletX[19:10]), 40'd638);
    chk("f10_y1", 40'(BulletY[19:10]), 40'd100);
    chk("f10_x0", 40'(BulletX[9:0]), 40'd338);
    frame(1'b0, 1'b0, bc);
    chk("f11_x1_clamp", 40'(BulletX[19:10]), 40'd639);
    frame(1'b0, 1'b0, bc);
    chk("f12_x1_bounced", 40'(BulletX[19:10]), 40'd637);
    chk("f12_x0", 40'(BulletX[9:0]), 40'd342);
    repeat (6) frame(1'b0, 1'b0, bc);

    // F19: fire edge during UPDATE, heading -Y near top wall
    TankX = 10'd100;
    TankY = 10'd1;
    Cos   = 8'sd0;
    Sin   = 8'sd64;
    frame(1'b0, 1'b1, bc);
    chk("f19_active", 40'(BulletActive), 40'b0111);
    chk("f19_x2", 40'(BulletX[29:20]), 40'd100);
    chk("f19_y2", 40'(BulletY[29:20]), 40'd1);
    frame(1'b0, 1'b0, bc);
    chk("f20_y2_clamp", 40'(BulletY[29:20]), 40'd0);
    frame(1'b0, 1'b0, bc);
    chk("f21_y2_bounced", 40'(BulletY[29:20]), 40'd2);
    chk("f21_x2", 40'(BulletX[29:20]), 40'd100);
    repeat (6) frame(1'b0, 1'b0, bc);

    // F28: fourth shot, negative heading components
    TankX = 10'd5;
    TankY = 10'd5;
    Cos   = -8'sd64;
    Sin   = -8'sd64;
    shoot();
    frame(1'b0, 1'b0, bc);
    chk("f28_active", 40'(BulletActive), 40'b1111);
    chk("f28_x3", 40'(BulletX[39:30]), 40'd5);
    chk("f28_y3", 40'(BulletY[39:30]), 40'd5);
    frame(1'b0, 1'b0, bc);
    chk("f29_x3", 40'(BulletX[39:30]), 40'd3);
    chk("f29_y3", 40'(BulletY[39:30]), 40'd7);
    repeat (7) frame(1'b0, 1'b0, bc);

    // F37: fifth shot with all slots full is dropped
    shoot();
    frame(1'b0, 1'b0, bc);
    chk("f37_active", 40'(BulletActive), 40'b1111);
    repeat (263) frame(1'b0, 1'b0, bc);
    chk("f300_active", 40'(BulletActive), 40'b1111);
    frame(1'b0, 1'b0, bc);
    chk("f301_slot0_expired", 40'(BulletActive), 40'b1110);

    // Reset while UPDATE is on slot 2
    @(negedge Clk) frame_vs = 1'b1;
    @(negedge Clk) frame_vs = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mid_busy", 40'(busy), 40'd1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_x", BulletX, 40'd0);
    chk("mid_rst_y", BulletY, 40'd0);
    chk("mid_rst_active", 40'(BulletActive), 40'd0);
    chk("mid_rst_busy", 40'(busy), 40'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    frame(1'b0, 1'b0, bc);
    chk("post_rst_busy_cycles", 40'(bc), 40'd6);
    chk("post_rst_active", 40'(BulletActive), 40'd0);
    chk("post_rst_x", BulletX, 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
